// File: rtl/pw_trigger_gen_pkg.sv
// Shared types and default sizing for the trigger pulse generator.
package pw_trigger_gen_pkg;

   localparam int unsigned PW_NUM_TRIGGER_PULSES = 8;
   localparam int unsigned PW_NUM_TRIGGER_WIDTH  = 4;
   localparam int unsigned PW_CNT_WIDTH          = 24;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DELAY = 2'd1,
      ST_PULSE = 2'd2
   } trig_state_t;

   // Requested pulse count limited to what the settings bus can describe.
   function automatic int unsigned clamp_num(input int unsigned num, input int unsigned max_num);
      return (num > max_num) ? max_num : num;
   endfunction

endpackage

// File: rtl/pw_trigger_gen.sv
// Trigger pulse generator: on an accepted match, plays out a programmed train of
// delay/high-time pairs on O_trigger, all in the trigger clock domain.
module pw_trigger_gen
   import pw_trigger_gen_pkg::*;
#(
   parameter int unsigned pNUM_TRIGGER_PULSES = PW_NUM_TRIGGER_PULSES,
   parameter int unsigned pNUM_TRIGGER_WIDTH  = PW_NUM_TRIGGER_WIDTH,
   parameter int unsigned pCNT_WIDTH          = PW_CNT_WIDTH
) (
   input  logic                                        trigger_clk,
   input  logic                                        reset,
   input  logic                                        I_match,
   input  logic                                        I_trigger_enable,
   input  logic [pNUM_TRIGGER_WIDTH-1:0]               I_num_triggers,
   input  logic [pCNT_WIDTH*pNUM_TRIGGER_PULSES-1:0]   I_trigger_delay,
   input  logic [pCNT_WIDTH*pNUM_TRIGGER_PULSES-1:0]   I_trigger_width,
   output logic                                        O_trigger,
   output logic                                        O_busy,
   output logic                                        O_done
);

   localparam int unsigned IDX_W = (pNUM_TRIGGER_PULSES > 1) ? $clog2(pNUM_TRIGGER_PULSES) : 1;
   localparam int unsigned NUM_W = $clog2(pNUM_TRIGGER_PULSES + 1);

   trig_state_t               state_q, state_d;
   logic [pCNT_WIDTH-1:0]     cnt_q, cnt_d;
   logic [IDX_W-1:0]          idx_q, idx_d;
   logic [NUM_W-1:0]          num_q, num_d;
   logic                      done_q, done_d;

   logic [NUM_W-1:0]          num_in;
   logic                      accept;
   logic [pCNT_WIDTH-1:0]     cur_width;
   logic [NUM_W-1:0]          seek_start;
   logic [NUM_W-1:0]          seek_limit;
   logic                      seek_found;
   trig_state_t               seek_state;
   logic [IDX_W-1:0]          seek_idx;
   logic [pCNT_WIDTH-1:0]     seek_cnt;
   logic                      take_seek;

   assign num_in    = NUM_W'(clamp_num(32'(I_num_triggers), pNUM_TRIGGER_PULSES));
   assign cur_width = I_trigger_width[idx_q*pCNT_WIDTH +: pCNT_WIDTH];

   // Matches are ignored while any part of the previous train is still visible.
   assign accept = I_match & I_trigger_enable & (I_num_triggers != '0) &
                   (state_q == ST_IDLE) & ~O_busy & ~O_done & ~done_q;

   assign seek_start = (state_q == ST_IDLE) ? NUM_W'(0) : NUM_W'(idx_q) + NUM_W'(1);
   assign seek_limit = (state_q == ST_IDLE) ? num_in : num_q;

   // First pulse at or after seek_start that needs a cycle: zero-delay,
   // zero-width entries collapse to nothing so back-to-back highs stay contiguous.
   always_comb begin
      seek_found = 1'b0;
      seek_state = ST_IDLE;
      seek_idx   = '0;
      seek_cnt   = '0;
      for (int unsigned j = 0; j < pNUM_TRIGGER_PULSES; j++) begin
         if (!seek_found && (j >= 32'(seek_start)) && (j < 32'(seek_limit))) begin
            if (I_trigger_delay[j*pCNT_WIDTH +: pCNT_WIDTH] != '0) begin
               seek_found = 1'b1;
               seek_state = ST_DELAY;
               seek_idx   = IDX_W'(j);
               seek_cnt   = I_trigger_delay[j*pCNT_WIDTH +: pCNT_WIDTH] - pCNT_WIDTH'(1);
            end else if (I_trigger_width[j*pCNT_WIDTH +: pCNT_WIDTH] != '0) begin
               seek_found = 1'b1;
               seek_state = ST_PULSE;
               seek_idx   = IDX_W'(j);
               seek_cnt   = I_trigger_width[j*pCNT_WIDTH +: pCNT_WIDTH] - pCNT_WIDTH'(1);
            end
         end
      end
   end

   // Next-state logic.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      num_d     = num_q;
      done_d    = 1'b0;
      take_seek = 1'b0;

      if (!I_trigger_enable) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
         idx_d   = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  num_d     = num_in;
                  take_seek = 1'b1;
               end
            end
            ST_DELAY: begin
               if (cnt_q == '0) begin
                  if (cur_width != '0) begin
                     state_d = ST_PULSE;
                     cnt_d   = cur_width - pCNT_WIDTH'(1);
                  end else begin
                     take_seek = 1'b1;
                  end
               end else begin
                  cnt_d = cnt_q - pCNT_WIDTH'(1);
               end
            end
            ST_PULSE: begin
               if (cnt_q == '0) begin
                  take_seek = 1'b1;
               end else begin
                  cnt_d = cnt_q - pCNT_WIDTH'(1);
               end
            end
            default: state_d = ST_IDLE;
         endcase

         if (take_seek) begin
            if (seek_found) begin
               state_d = seek_state;
               idx_d   = seek_idx;
               cnt_d   = seek_cnt;
            end else begin
               state_d = ST_IDLE;
               idx_d   = '0;
               cnt_d   = '0;
               done_d  = 1'b1;
            end
         end
      end
   end

   // State register plus output stage; outputs trail the state by one cycle.
   always_ff @(posedge trigger_clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         idx_q     <= '0;
         num_q     <= '0;
         done_q    <= 1'b0;
         O_trigger <= 1'b0;
         O_busy    <= 1'b0;
         O_done    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         num_q     <= num_d;
         done_q    <= done_d;
         O_trigger <= I_trigger_enable & (state_q == ST_PULSE);
         O_busy    <= I_trigger_enable & (state_q != ST_IDLE);
         O_done    <= I_trigger_enable & done_q;
      end
   end

endmodule

// File: tb/tb_pw_trigger_gen.sv
// Bench for pw_trigger_gen: per-cycle compare against a waveform model plus
// hand-computed expectations for the directed scenarios.
module tb_pw_trigger_gen;

   localparam int P    = 8;
   localparam int NW   = 4;
   localparam int CW   = 24;
   localparam int MAXC = 1024;

   logic              clk = 1'b0;
   logic              reset;
   logic              I_match;
   logic              I_trigger_enable;
   logic [NW-1:0]     I_num_triggers;
   logic [CW*P-1:0]   I_trigger_delay;
   logic [CW*P-1:0]   I_trigger_width;
   logic              O_trigger;
   logic              O_busy;
   logic              O_done;

   int cfg_d [P];
   int cfg_w [P];
   int cfg_num;

   bit exp_trig [MAXC];
   bit exp_busy [MAXC];
   bit exp_done [MAXC];
   bit dut_trig [MAXC];
   bit dut_busy [MAXC];
   bit dut_done [MAXC];

   int cyc      = -1;
   int last_end = -100;
   int checks   = 0;
   int errors   = 0;

   pw_trigger_gen #(
      .pNUM_TRIGGER_PULSES (P),
      .pNUM_TRIGGER_WIDTH  (NW),
      .pCNT_WIDTH          (CW)
   ) dut (
      .trigger_clk      (clk),
      .reset            (reset),
      .I_match          (I_match),
      .I_trigger_enable (I_trigger_enable),
      .I_num_triggers   (I_num_triggers),
      .I_trigger_delay  (I_trigger_delay),
      .I_trigger_width  (I_trigger_width),
      .O_trigger        (O_trigger),
      .O_busy           (O_busy),
      .O_done           (O_done)
   );

   always #5 clk = ~clk;

   always_comb begin
      I_num_triggers = NW'(cfg_num);
      for (int i = 0; i < P; i++) begin
         I_trigger_delay[i*CW +: CW] = CW'(cfg_d[i]);
         I_trigger_width[i*CW +: CW] = CW'(cfg_w[i]);
      end
   end

   task automatic check(input string name, input int act, input int exp, input int at);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0d expected %0d", name, at, act, exp);
      end
   endtask

   function automatic int count_hi(input int sel, input int a, input int b);
      int n = 0;
      for (int k = a; k <= b; k++) begin
         if (k >= 0 && k < MAXC) begin
            if (sel == 0 && dut_trig[k]) n++;
            if (sel == 1 && dut_busy[k]) n++;
            if (sel == 2 && dut_done[k]) n++;
         end
      end
      return n;
   endfunction

   function automatic void clear_from(input int c);
      for (int k = c; k < MAXC; k++) begin
         exp_trig[k] = 1'b0;
         exp_busy[k] = 1'b0;
         exp_done[k] = 1'b0;
      end
   endfunction

   // Model of one clock edge c: outputs visible after edge c are exp_*[c].
   function automatic void model_edge(input int c);
      int n;
      int p;
      if (reset || !I_trigger_enable) begin
         clear_from(c);
         last_end = c - 1;
      end else if (I_match && cfg_num != 0 && (c - 1) > last_end) begin
         n = (cfg_num > P) ? P : cfg_num;
         p = c + 1;
         for (int i = 0; i < n; i++) begin
            p += cfg_d[i];
            for (int k = 0; k < cfg_w[i]; k++)
               if (p + k < MAXC) exp_trig[p+k] = 1'b1;
            p += cfg_w[i];
         end
         for (int k = c + 1; k < p; k++)
            if (k < MAXC) exp_busy[k] = 1'b1;
         if (p < MAXC) exp_done[p] = 1'b1;
         last_end = p;
      end
   endfunction

   always @(posedge clk) begin
      int c;
      c   = cyc + 1;
      cyc = c;
      model_edge(c);
      #1;
      if (c < MAXC) begin
         dut_trig[c] = O_trigger;
         dut_busy[c] = O_busy;
         dut_done[c] = O_done;
         check("trigger", int'(O_trigger), int'(exp_trig[c]), c);
         check("busy",    int'(O_busy),    int'(exp_busy[c]), c);
         check("done",    int'(O_done),    int'(exp_done[c]), c);
      end
   end

   task automatic clear_cfg();
      for (int i = 0; i < P; i++) begin
         cfg_d[i] = 0;
         cfg_w[i] = 0;
      end
      cfg_num = 0;
   endtask

   task automatic pulse_match(output int t);
      I_match = 1'b1;
      @(negedge clk);
      I_match = 1'b0;
      t = cyc;
   endtask

   initial begin
      int t;
      int t2;
      reset            = 1'b1;
      I_match          = 1'b0;
      I_trigger_enable = 1'b1;
      clear_cfg();
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("reset_trig", int'(dut_trig[1]), 0, 1);
      check("reset_busy", int'(dut_busy[1]), 0, 1);

      // single one-cycle pulse, no delay
      cfg_num = 1; cfg_d[0] = 0; cfg_w[0] = 1;
      @(negedge clk);
      pulse_match(t);
      repeat (8) @(negedge clk);
      check("t1_pre",  int'(dut_trig[t]),   0, t);
      check("t1_hi",   int'(dut_trig[t+1]), 1, t+1);
      check("t1_lo",   int'(dut_trig[t+2]), 0, t+2);
      check("t1_done", int'(dut_done[t+2]), 1, t+2);
      check("t1_busy", int'(dut_busy[t+2]), 0, t+2);

      // two pulses with delays
      clear_cfg();
      cfg_num = 2; cfg_d[0] = 5; cfg_d[1] = 3; cfg_w[0] = 4; cfg_w[1] = 2;
      @(negedge clk);
      pulse_match(t);
      repeat (20) @(negedge clk);
      check("t2_rise0", int'(dut_trig[t+6]),  1, t+6);
      check("t2_pre0",  int'(dut_trig[t+5]),  0, t+5);
      check("t2_fall0", int'(dut_trig[t+10]), 0, t+10);
      check("t2_rise1", int'(dut_trig[t+13]), 1, t+13);
      check("t2_hi1",   int'(dut_trig[t+14]), 1, t+14);
      check("t2_count", count_hi(0, t, t+19), 6, t);
      check("t2_busy",  int'(dut_busy[t+14]), 1, t+14);
      check("t2_idle",  int'(dut_busy[t+15]), 0, t+15);

      // zero delays with a zero-width middle pulse
      clear_cfg();
      cfg_num = 3; cfg_w[0] = 2; cfg_w[1] = 0; cfg_w[2] = 3;
      @(negedge clk);
      pulse_match(t);
      repeat (12) @(negedge clk);
      check("t3_count", count_hi(0, t, t+11), 5, t);
      check("t3_first", int'(dut_trig[t+1]), 1, t+1);
      check("t3_last",  int'(dut_trig[t+5]), 1, t+5);
      check("t3_done",  count_hi(2, t, t+11), 1, t);

      // second match two cycles later is dropped
      clear_cfg();
      cfg_num = 1; cfg_d[0] = 10; cfg_w[0] = 3;
      @(negedge clk);
      pulse_match(t);
      @(negedge clk);
      I_match = 1'b1;
      @(negedge clk);
      I_match = 1'b0;
      repeat (25) @(negedge clk);
      check("t4_rise",  int'(dut_trig[t+11]), 1, t+11);
      check("t4_count", count_hi(0, t, t+26), 3, t);
      check("t4_done",  count_hi(2, t, t+26), 1, t);

      // matches while busy and while done is high are ignored
      clear_cfg();
      cfg_num = 1; cfg_w[0] = 1;
      @(negedge clk);
      pulse_match(t);
      @(negedge clk);
      I_match = 1'b1;
      repeat (2) @(negedge clk);
      I_match = 1'b0;
      repeat (10) @(negedge clk);
      check("t5_count", count_hi(0, t, t+12), 1, t);
      check("t5_done",  count_hi(2, t, t+12), 1, t);

      // enable dropped during a long pulse
      clear_cfg();
      cfg_num = 1; cfg_d[0] = 2; cfg_w[0] = 100;
      @(negedge clk);
      pulse_match(t);
      repeat (20) @(negedge clk);
      I_trigger_enable = 1'b0;
      @(negedge clk);
      I_trigger_enable = 1'b1;
      repeat (10) @(negedge clk);
      check("t6_hi",    int'(dut_trig[t+20]), 1, t+20);
      check("t6_abort", int'(dut_trig[t+21]), 0, t+21);
      check("t6_busy",  int'(dut_busy[t+21]), 0, t+21);
      check("t6_count", count_hi(0, t, t+30), 18, t);
      check("t6_done",  count_hi(2, t, t+30), 0, t);

      // reset during a delay, then a fresh train
      clear_cfg();
      cfg_num = 2; cfg_d[0] = 20; cfg_d[1] = 1; cfg_w[0] = 3; cfg_w[1] = 3;
      @(negedge clk);
      pulse_match(t);
      repeat (4) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      cfg_d[0] = 2; cfg_d[1] = 1; cfg_w[0] = 1; cfg_w[1] = 2;
      @(negedge clk);
      pulse_match(t2);
      repeat (12) @(negedge clk);
      check("t7_busy_pre", int'(dut_busy[t+4]), 1, t+4);
      check("t7_busy_rst", int'(dut_busy[t+5]), 0, t+5);
      check("t7_quiet",    count_hi(0, t, t2), 0, t);
      check("t7_hi0",      int'(dut_trig[t2+3]), 1, t2+3);
      check("t7_gap",      int'(dut_trig[t2+4]), 0, t2+4);
      check("t7_hi1",      int'(dut_trig[t2+6]), 1, t2+6);
      check("t7_done",     int'(dut_done[t2+7]), 1, t2+7);

      // pulse count clamped to 8
      clear_cfg();
      cfg_num = 15;
      for (int i = 0; i < P; i++) begin
         cfg_d[i] = 1;
         cfg_w[i] = 1;
      end
      @(negedge clk);
      pulse_match(t);
      repeat (25) @(negedge clk);
      check("t8_count", count_hi(0, t, t+24), 8, t);
      check("t8_last",  int'(dut_trig[t+16]), 1, t+16);
      check("t8_done",  int'(dut_done[t+17]), 1, t+17);

      // zero pulses requested: no train
      clear_cfg();
      cfg_d[0] = 1; cfg_w[0] = 1;
      @(negedge clk);
      pulse_match(t);
      repeat (6) @(negedge clk);
      check("t9_busy", count_hi(1, t, t+5), 0, t);

      // zero width after a delay still honours the delay
      clear_cfg();
      cfg_num = 2; cfg_d[0] = 3; cfg_d[1] = 2; cfg_w[0] = 0; cfg_w[1] = 2;
      @(negedge clk);
      pulse_match(t);
      repeat (12) @(negedge clk);
      check("t10_rise",  int'(dut_trig[t+6]), 1, t+6);
      check("t10_pre",   int'(dut_trig[t+5]), 0, t+5);
      check("t10_count", count_hi(0, t, t+11), 2, t);
      check("t10_done",  int'(dut_done[t+8]), 1, t+8);

      // match with enable low is ignored
      I_trigger_enable = 1'b0;
      pulse_match(t);
      I_trigger_enable = 1'b1;
      repeat (8) @(negedge clk);
      check("t11_busy", count_hi(1, t, t+7), 0, t);

      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
